// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Purpose
//   Merges two AXI-Stream slave ports onto one master stream with whole-packet
//   granularity. Once a port is granted, it owns the master port until its
//   tlast beat is accepted. The grant never switches mid-packet. Ties in IDLE
//   are broken round-robin against the last granted port.
//
//   The data path is a zero-latency combinational mux, so the granted slave
//   sees m_tready directly. The FSM always returns to IDLE for one cycle after
//   every packet. That bubble is where the next arbitration decision is taken.
//
// Ports
//   aclk                     sole clock, rising edge
//   reset                    synchronous, active-high
//   s0_* / s1_*              slave streams (tdata, tkeep, tuser, tvalid, tlast)
//   s0_tready / s1_tready    slave ready; only the granted port can be high
//   m_*                      merged master stream (to the FIFO write side)
//   m_tready                 downstream ready
//   m_tid                    source port of the current beat
//   pkt_cnt0 / pkt_cnt1      packets fully forwarded per port (wrapping)
//   busy                     high while a packet is locked to a port
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                          aclk,
  input  logic                          reset,

  input  logic [AXIS_DATA_WIDTH-1:0]    s0_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s0_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s0_tuser,
  input  logic                          s0_tvalid,
  input  logic                          s0_tlast,
  output logic                          s0_tready,

  input  logic [AXIS_DATA_WIDTH-1:0]    s1_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s1_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s1_tuser,
  input  logic                          s1_tvalid,
  input  logic                          s1_tlast,
  output logic                          s1_tready,

  output logic [AXIS_DATA_WIDTH-1:0]    m_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_tuser,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic                          m_tid,

  output logic [CNT_WIDTH-1:0]          pkt_cnt0,
  output logic [CNT_WIDTH-1:0]          pkt_cnt1,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   busy_q, busy_d;
  logic   tid_q, tid_d;

  // Per-port views of the slave handshake bits, indexed by port number.
  logic [1:0] s_tvalid;
  logic [1:0] s_tlast;
  assign s_tvalid = {s1_tvalid, s0_tvalid};
  assign s_tlast  = {s1_tlast,  s0_tlast};

  // lock is forced low during reset. That abandons an in-flight packet in the
  // very cycle reset is seen, without waiting for the state flop to clear.
  logic lock;
  logic sel;
  logic xfer;
  logic pkt_done;
  logic [1:0] done_vec;

  assign lock     = (state_q != IDLE) && !reset;
  assign sel      = (state_q == LOCK1);
  assign xfer     = lock && s_tvalid[sel] && m_tready;
  assign pkt_done = xfer && s_tlast[sel];
  assign done_vec = {pkt_done && sel, pkt_done && !sel};

  // ---------------------------------------------------------------------------
  // Zero-latency data path
  // ---------------------------------------------------------------------------
  always_comb begin
    m_tdata = sel ? s1_tdata : s0_tdata;
    m_tkeep = sel ? s1_tkeep : s0_tkeep;
    m_tuser = sel ? s1_tuser : s0_tuser;
    m_tlast = sel ? s1_tlast : s0_tlast;
  end

  assign m_tvalid  = lock && s_tvalid[sel];
  assign s0_tready = lock && !sel && m_tready;
  assign s1_tready = lock &&  sel && m_tready;

  // busy and m_tid are registered images of the state. They are also gated by
  // reset, so both read 0 for the whole time reset is held.
  assign busy  = busy_q && !reset;
  assign m_tid = tid_q  && !reset;

  // ---------------------------------------------------------------------------
  // Arbitration / packet lock
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (s_tvalid == 2'b11) begin
          // Round-robin: the port that did not win last time goes first.
          state_d      = last_grant_q ? LOCK0 : LOCK1;
          last_grant_d = !last_grant_q;
        end else if (s_tvalid[0]) begin
          state_d      = LOCK0;
          last_grant_d = 1'b0;
        end else if (s_tvalid[1]) begin
          state_d      = LOCK1;
          last_grant_d = 1'b1;
        end
      end
      LOCK0, LOCK1: begin
        // Only the accepted tlast beat releases the lock. Stalls on either
        // side simply hold the current state.
        if (pkt_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    tid_d  = (state_d == LOCK1);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // port 0 wins the first tie after reset
      busy_q       <= 1'b0;
      tid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      tid_q        <= tid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port packet counters (wrap naturally at 2^CNT_WIDTH)
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q [2];
  logic [CNT_WIDTH-1:0] cnt_d [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (done_vec[gi]) begin
          cnt_d[gi] = cnt_q[gi] + CNT_WIDTH'(1);
        end
      end

      always_ff @(posedge aclk) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign pkt_cnt0 = cnt_q[0];
  assign pkt_cnt1 = cnt_q[1];

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_arbiter
//
// Drives both slave ports from per-port packet queues. Each cycle the DUT
// outputs are compared against a packet-level reference model. The model keeps
// only three things: who owns the master port, which port wins the next tie,
// and how many packets each port has completed. Directed scenarios come first.
// Each one is pinned with literal expectations. A long random run follows.
// -----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 8;
  localparam int CW = 4;
  localparam int CNT_MOD = 1 << CW;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          reset;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
  logic          s0_tvalid, s1_tvalid, m_tvalid;
  logic          s0_tlast, s1_tlast, m_tlast;
  logic          s0_tready, s1_tready, m_tready;
  logic          m_tid, busy;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  axis_packet_arbiter #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_TUSER_WIDTH(UW),
    .CNT_WIDTH       (CW)
  ) dut (
    .aclk     (aclk),
    .reset    (reset),
    .s0_tdata (s0_tdata),
    .s0_tkeep (s0_tkeep),
    .s0_tuser (s0_tuser),
    .s0_tvalid(s0_tvalid),
    .s0_tlast (s0_tlast),
    .s0_tready(s0_tready),
    .s1_tdata (s1_tdata),
    .s1_tkeep (s1_tkeep),
    .s1_tuser (s1_tuser),
    .s1_tvalid(s1_tvalid),
    .s1_tlast (s1_tlast),
    .s1_tready(s1_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tuser  (m_tuser),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .m_tid    (m_tid),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1),
    .busy     (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t srcq0[$];
  beat_t srcq1[$];
  logic  ven0, ven1;

  // Reference model state
  int owner;     // -1 = no packet in flight, else owning port
  int prefer;    // port that wins the next tie
  int cnt0, cnt1;
  int tot0, tot1;

  // Log of accepted beats, as seen on the DUT master port
  int            log_tid[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];

  int cyc;
  int errors;
  int checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = (i == len - 1);
      if (port == 0) srcq0.push_back(b);
      else           srcq1.push_back(b);
    end
  endtask

  task automatic drive();
    if (srcq0.size() > 0) begin
      s0_tdata = srcq0[0].data; s0_tkeep = srcq0[0].keep;
      s0_tuser = srcq0[0].user; s0_tlast = srcq0[0].last;
      s0_tvalid = ven0;
    end else begin
      s0_tdata = '0; s0_tkeep = '0; s0_tuser = '0; s0_tlast = 1'b0;
      s0_tvalid = 1'b0;
    end
    if (srcq1.size() > 0) begin
      s1_tdata = srcq1[0].data; s1_tkeep = srcq1[0].keep;
      s1_tuser = srcq1[0].user; s1_tlast = srcq1[0].last;
      s1_tvalid = ven1;
    end else begin
      s1_tdata = '0; s1_tkeep = '0; s1_tuser = '0; s1_tlast = 1'b0;
      s1_tvalid = 1'b0;
    end
  endtask

  // Compare every DUT output against what the model says it must be now.
  task automatic compare();
    int   eff;
    logic ev;
    eff = reset ? -1 : owner;
    ev  = (eff == 0) ? s0_tvalid : (eff == 1) ? s1_tvalid : 1'b0;
    chk("busy",      64'(busy),      64'(eff >= 0));
    chk("m_tid",     64'(m_tid),     64'(eff == 1));
    chk("s0_tready", 64'(s0_tready), 64'(eff == 0 && m_tready));
    chk("s1_tready", 64'(s1_tready), 64'(eff == 1 && m_tready));
    chk("m_tvalid",  64'(m_tvalid),  64'(ev));
    if (ev) begin
      if (eff == 0) begin
        chk("m_tdata", 64'(m_tdata), 64'(srcq0[0].data));
        chk("m_tkeep", 64'(m_tkeep), 64'(srcq0[0].keep));
        chk("m_tuser", 64'(m_tuser), 64'(srcq0[0].user));
        chk("m_tlast", 64'(m_tlast), 64'(srcq0[0].last));
      end else begin
        chk("m_tdata", 64'(m_tdata), 64'(srcq1[0].data));
        chk("m_tkeep", 64'(m_tkeep), 64'(srcq1[0].keep));
        chk("m_tuser", 64'(m_tuser), 64'(srcq1[0].user));
        chk("m_tlast", 64'(m_tlast), 64'(srcq1[0].last));
      end
    end
    chk("pkt_cnt0", 64'(pkt_cnt0), 64'(cnt0));
    chk("pkt_cnt1", 64'(pkt_cnt1), 64'(cnt1));
  endtask

  // Apply the packet-level rules for what the coming clock edge does.
  task automatic advance();
    logic lst;
    if (reset) begin
      owner = -1; prefer = 0; cnt0 = 0; cnt1 = 0;
      srcq0.delete(); srcq1.delete();   // sources abandon their packets too
    end else if (owner < 0) begin
      if (s0_tvalid && s1_tvalid) owner = prefer;
      else if (s0_tvalid)         owner = 0;
      else if (s1_tvalid)         owner = 1;
      if (owner >= 0) prefer = 1 - owner;
    end else if (owner == 0 && s0_tvalid && m_tready) begin
      log_tid.push_back(int'(m_tid)); log_data.push_back(m_tdata); log_cyc.push_back(cyc);
      lst = srcq0[0].last;
      void'(srcq0.pop_front());
      if (lst) begin cnt0 = (cnt0 + 1) % CNT_MOD; tot0++; owner = -1; end
    end else if (owner == 1 && s1_tvalid && m_tready) begin
      log_tid.push_back(int'(m_tid)); log_data.push_back(m_tdata); log_cyc.push_back(cyc);
      lst = srcq1[0].last;
      void'(srcq1.pop_front());
      if (lst) begin cnt1 = (cnt1 + 1) % CNT_MOD; tot1++; owner = -1; end
    end
  endtask

  task automatic step();
    drive();
    #1;
    compare();
    advance();
    @(negedge aclk);
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (srcq0.size() == 0 && srcq1.size() == 0 && owner < 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (srcq0.size() == 0 && srcq1.size() == 0 && owner < 0) done = 1'b1;
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  task automatic clear_log();
    log_tid.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int            c0;
    int            pat[4];
    int            exp_tid[8];
    logic [DW-1:0] exp_data[4];

    errors = 0; checks = 0; cyc = 0;
    owner = -1; prefer = 0; cnt0 = 0; cnt1 = 0; tot0 = 0; tot1 = 0;
    reset = 1'b1; m_tready = 1'b0; ven0 = 1'b0; ven1 = 1'b0;
    drive();
    @(negedge aclk);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("reset_tid", 64'(m_tid), 64'd0);

    // Simultaneous 3-beat packets: port 0 first, one bubble, then port 1.
    $display("scenario: simultaneous 3-beat packets");
    clear_log();
    m_tready = 1'b1; ven0 = 1'b1; ven1 = 1'b1;
    push_pkt(0, 3); push_pkt(1, 3);
    c0 = cyc;
    run_until_idle(50);
    chk("sim_beats", 64'(log_tid.size()), 64'd6);
    if (log_tid.size() == 6) begin
      exp_tid = '{0, 0, 0, 1, 1, 1, 0, 0};
      for (int i = 0; i < 6; i++) chk("sim_tid", 64'(log_tid[i]), 64'(exp_tid[i]));
      chk("sim_latency", 64'(log_cyc[0] - c0), 64'd1);
      chk("sim_bubble", 64'(log_cyc[3] - log_cyc[2]), 64'd2);
    end
    chk("sim_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("sim_cnt1", 64'(pkt_cnt1), 64'd1);

    // Back-to-back single-beat packets on both ports alternate.
    $display("scenario: alternating single-beat packets");
    clear_log();
    for (int i = 0; i < 4; i++) begin push_pkt(0, 1); push_pkt(1, 1); end
    run_until_idle(60);
    exp_tid = '{0, 1, 0, 1, 0, 1, 0, 1};
    chk("rr_beats", 64'(log_tid.size()), 64'd8);
    if (log_tid.size() == 8)
      for (int i = 0; i < 8; i++) chk("rr_tid", 64'(log_tid[i]), 64'(exp_tid[i]));

    // 4-beat packet on port 1 with m_tready stalls while port 0 waits.
    $display("scenario: stalled 4-beat packet on port 1");
    clear_log();
    push_pkt(1, 4);
    for (int i = 0; i < 4; i++) exp_data[i] = srcq1[i].data;
    step();                      // port 1 alone -> locked
    push_pkt(0, 1);
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < 60; i++) begin
      if (srcq0.size() == 0 && srcq1.size() == 0 && owner < 0) break;
      m_tready = pat[i % 4][0];
      step();
    end
    m_tready = 1'b1;
    run_until_idle(20);
    chk("stall_beats", 64'(log_tid.size()), 64'd5);
    if (log_tid.size() == 5) begin
      exp_tid = '{1, 1, 1, 1, 0, 0, 0, 0};
      for (int i = 0; i < 5; i++) chk("stall_tid", 64'(log_tid[i]), 64'(exp_tid[i]));
      for (int i = 0; i < 4; i++) chk("stall_data", 64'(log_data[i]), 64'(exp_data[i]));
    end

    // Counter wrap at CNT_WIDTH = 4.
    $display("scenario: packet counter wrap");
    pulse_reset();
    ven1 = 1'b0;
    for (int i = 0; i < 15; i++) push_pkt(0, 1);
    run_until_idle(100);
    chk("wrap_cnt0_15", 64'(pkt_cnt0), 64'd15);
    push_pkt(0, 1);
    run_until_idle(10);
    chk("wrap_cnt0_0", 64'(pkt_cnt0), 64'd0);

    // Reset on beat 2 of a 5-beat packet.
    $display("scenario: reset mid-packet");
    ven0 = 1'b1; ven1 = 1'b1; m_tready = 1'b1;
    clear_log();
    push_pkt(0, 5);
    for (int i = 0; i < 20; i++) begin
      if (log_tid.size() >= 1) break;
      step();
    end
    chk("mid_first_beat", 64'(log_tid.size()), 64'd1);
    pulse_reset();
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_s0_tready", 64'(s0_tready), 64'd0);
    chk("mid_s1_tready", 64'(s1_tready), 64'd0);
    chk("mid_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("mid_cnt1", 64'(pkt_cnt1), 64'd0);
    clear_log();
    push_pkt(1, 1);
    run_until_idle(20);
    chk("mid_new_beats", 64'(log_tid.size()), 64'd1);
    if (log_tid.size() == 1) chk("mid_new_tid", 64'(log_tid[0]), 64'd1);
    chk("mid_new_cnt1", 64'(pkt_cnt1), 64'd1);

    // Random traffic.
    $display("scenario: random traffic");
    tot0 = 0; tot1 = 0;
    pulse_reset();
    for (int n = 0; n < 10000; n++) begin
      if (srcq0.size() < 2) push_pkt(0, int'($urandom_range(1, 6)));
      if (srcq1.size() < 2) push_pkt(1, int'($urandom_range(1, 6)));
      ven0 = ($urandom_range(0, 3) != 0);
      ven1 = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    ven0 = 1'b1; ven1 = 1'b1; m_tready = 1'b1;
    run_until_idle(200);
    chk("rand_some_pkts0", 64'(tot0 > 100), 64'd1);
    chk("rand_some_pkts1", 64'(tot1 > 100), 64'd1);
    chk("rand_cnt0", 64'(pkt_cnt0), 64'(tot0 % CNT_MOD));
    chk("rand_cnt1", 64'(pkt_cnt1), 64'(tot1 % CNT_MOD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 512, tdata width of all ports.
REQ-002 SHALL have parameter AXIS_TUSER_WIDTH, default 256, tuser width of all ports.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of each per-port packet counter.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s0_tdata/s0_tkeep/s0_tuser/s0_tvalid/s0_tlast  in  DW/DW8/UW/1/1  slave stream port 0.
REQ-007 s0_tready  out  1  port 0 ready.
REQ-008 s1_tdata/s1_tkeep/s1_tuser/s1_tvalid/s1_tlast  in  DW/DW8/UW/1/1  slave stream port 1.
REQ-009 s1_tready  out  1  port 1 ready.
REQ-010 m_tdata/m_tkeep/m_tuser/m_tvalid/m_tlast  out  DW/DW8/UW/1/1  merged master stream, feeds the double-width FIFO write side.
REQ-011 m_tready  in  1  downstream ready (FIFO write_tready).
REQ-012 m_tid  out  1  source port of the current beat (0 or 1).
REQ-013 pkt_cnt0, pkt_cnt1  out  CNT_WIDTH each  count of packets fully forwarded from port 0 / port 1.
REQ-014 busy  out  1  high while a packet is locked to a port.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, LOCK0, LOCK1.
REQ-016 In IDLE: all s*_tready = 0, m_tvalid = 0, busy = 0.
REQ-017 In IDLE, if only sN_tvalid is high, the next state SHALL be LOCKN.
REQ-018 In IDLE, if both tvalid are high, the next state SHALL be the lock for the port not equal to last_grant (round-robin).
REQ-019 last_grant SHALL update to N on each entry into LOCKN.
REQ-020 In IDLE with no tvalid, the FSM SHALL stay in IDLE and last_grant SHALL hold.
REQ-021 In LOCKN: m_tdata/tkeep/tuser/tlast/tvalid = sN_* combinationally (zero latency), sN_tready = m_tready, the other port's tready = 0, m_tid = N, busy = 1.
REQ-022 A beat SHALL transfer only when sN_tvalid & m_tready; data and sideband SHALL pass unmodified, and no beat SHALL be dropped, duplicated or reordered.
REQ-023 On a transferred beat with tlast = 1 in LOCKN, the FSM SHALL return to IDLE, and pkt_cntN SHALL increment by 1, wrapping modulo 2^CNT_WIDTH.
REQ-024 The grant SHALL never switch mid-packet, regardless of the other port's tvalid or of m_tready stalls of any length.
REQ-025 Each packet SHALL incur exactly one IDLE bubble cycle between its tlast beat and the next packet's first beat; minimum arbitration latency from tvalid to first m_tvalid = 1 cycle.
REQ-026 A single-beat packet (tlast on the first beat) SHALL be handled as a complete packet: lock, one beat, return to IDLE.
REQ-027 sN_tvalid falling mid-packet SHALL hold LOCKN with m_tvalid = 0 until the packet resumes.
REQ-028 With m_tready held low (FIFO full), the FSM SHALL hold state and both counters SHALL hold.

Reset
REQ-029 While reset = 1 at a clock edge: state = IDLE, last_grant = 1 (port 0 wins the first tie), pkt_cnt0 = pkt_cnt1 = 0.
REQ-030 During and after reset, outputs SHALL be: all tready = 0, m_tvalid = 0, busy = 0, m_tid = 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately; any remaining beats are not forwarded as part of it, and the first post-reset arbitration starts fresh from IDLE.
REQ-032 Datapath registers need no reset; only the FSM, last_grant and the counters are reset.

Verification
REQ-033 Both ports present a 3-beat packet simultaneously after reset, m_tready = 1 -> port 0's 3 beats (m_tid = 0), one bubble cycle, port 1's 3 beats; pkt_cnt0 = pkt_cnt1 = 1.
REQ-034 Port 0 streams back-to-back 1-beat packets while port 1 holds tvalid -> grants alternate 0,1,0,1; no port is starved.
REQ-035 m_tready toggles 1,0,0,1 during a 4-beat packet on port 1 while port 0 is valid -> exactly 4 beats on m_*, in order, no switch to port 0 until tlast.
REQ-036 pkt_cnt0 preset near wrap (CNT_WIDTH = 4, 15 packets then 1 more) -> pkt_cnt0 reads 15, then 0.
REQ-037 reset pulsed on beat 2 of a 5-beat packet -> next cycle all tready = 0, busy = 0, counters = 0; a new packet then arbitrates from IDLE.
REQ-038 Random valid/ready on both ports for 10k cycles with scoreboard -> per-port beat order preserved, no interleaving within packets, and counters match scoreboard packet counts.
